// File: rtl/byte_inst_sequencer_if.sv
// Instruction handshake plus the byte_manip drive/return bus around byte_inst_sequencer.
interface byte_inst_sequencer_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       inst;
    logic              inst_valid;
    logic              inst_ready;
    logic [2:0]        bm_op;
    logic [DATA_W-1:0] bm_dst_in;
    logic [7:0]        bm_byte;
    logic              bm_E;
    logic [DATA_W-1:0] bm_dst_out;
    logic              done;
    logic              illegal;

    modport slave (
        input  inst, inst_valid, bm_dst_out,
        output inst_ready, bm_op, bm_dst_in, bm_byte, bm_E, done, illegal
    );

    modport master (
        output inst, inst_valid, bm_dst_out,
        input  inst_ready, bm_op, bm_dst_in, bm_byte, bm_E, done, illegal
    );
endinterface

// File: rtl/byte_inst_sequencer.sv
// Accepts one byte-manipulation instruction at a time, feeds byte_manip from a register
// bank and writes its result back: IDLE -> DECODE -> EXEC -> WB (illegal words skip EXEC).
module byte_inst_sequencer #(
    parameter int unsigned       NREG    = 8,
    parameter int unsigned       DATA_W  = 16,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    byte_inst_sequencer_if.slave    bus,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DATA_W-1:0]       dbg_data
);
    localparam logic [2:0]  OP_SWPB     = 3'd4;
    localparam logic [12:0] SWPB_PREFIX = 13'b0100_1101_1000_0;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] op;
        logic [7:0] imm;
        logic [2:0] dst;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] w);
        dec_t d;
        d.legal = 1'b0;
        d.op    = 3'd0;
        d.imm   = 8'd0;
        d.dst   = w[2:0];
        if (w[15:13] == 3'b011) begin
            d.legal = 1'b1;
            d.op    = {1'b0, w[12:11]};
            d.imm   = w[10:3];
        end else if (w[15:3] == SWPB_PREFIX) begin
            d.legal = 1'b1;
            d.op    = OP_SWPB;
        end
        return d;
    endfunction

    state_t            state, state_d;
    logic [DATA_W-1:0] bank [NREG];
    logic [15:0]       inst_p0;
    logic [2:0]        dst_p1;
    logic [DATA_W-1:0] result_p2;
    logic              illegal_q;
    logic [2:0]        bm_op_q;
    logic [7:0]        bm_byte_q;
    logic [DATA_W-1:0] bm_dst_in_q;
    logic              inst_ready_c, bm_e_c, done_c, illegal_c;
    logic              accept, wb_en;
    dec_t              dec;

    assign dec    = decode(inst_p0);
    assign accept = bus.inst_valid && inst_ready_c;
    assign wb_en  = done_c && !illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        inst_ready_c = 1'b0;
        bm_e_c       = 1'b0;
        done_c       = 1'b0;
        illegal_c    = 1'b0;
        case (state)
            IDLE: begin
                inst_ready_c = 1'b1;
                if (bus.inst_valid) state_d = DECODE;
            end
            DECODE: state_d = dec.legal ? EXEC : WB;
            EXEC: begin
                bm_e_c  = 1'b1;
                state_d = WB;
            end
            WB: begin
                done_c    = 1'b1;
                illegal_c = illegal_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: instruction latched at accept; p1: destination index from decode;
    // p2: byte_manip result captured at the end of EXEC.
    always_ff @(posedge clk) begin
        if (accept)           inst_p0   <= bus.inst;
        if (state == DECODE)  dst_p1    <= dec.dst;
        if (state == EXEC)    result_p2 <= bus.bm_dst_out;
    end

    // byte_manip operands only move on the DECODE->EXEC edge, so they are stable
    // for the whole EXEC cycle and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bm_op_q     <= 3'd0;
            bm_byte_q   <= 8'd0;
            bm_dst_in_q <= '0;
            illegal_q   <= 1'b0;
        end else if (state == DECODE) begin
            illegal_q <= !dec.legal;
            if (dec.legal) begin
                bm_op_q     <= dec.op;
                bm_byte_q   <= dec.imm;
                bm_dst_in_q <= bank[dec.dst];
            end
        end
    end

    // Stage WB: register bank write; illegal words retire without touching it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) bank[i] <= RST_VAL;
        end else if (wb_en) begin
            bank[dst_p1] <= result_p2;
        end
    end

    assign bus.inst_ready = inst_ready_c;
    assign bus.bm_op      = bm_op_q;
    assign bus.bm_byte    = bm_byte_q;
    assign bus.bm_dst_in  = bm_dst_in_q;
    assign bus.bm_E       = bm_e_c;
    assign bus.done       = done_c;
    assign bus.illegal    = illegal_c;
    assign dbg_data       = bank[dbg_addr];
endmodule
